// File: rtl/compound_rr_arbiter_pkg.sv
// Types and constants local to the compound round-robin arbiter.
package compound_rr_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ArbState_t;

    localparam int CNT_W = 32;

endpackage

// File: rtl/testbasic13_types.sv
// Shared CompoundType definition used by TestBasic13-style consumers and their feeders.
package testbasic13_types;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mode_t;

    typedef struct packed {
        mode_t       mode;
        logic [31:0] x;
        logic [31:0] y;
    } CompoundType;

endpackage

// File: rtl/compound_rr_arbiter_if.sv
// Requester and consumer handshake bundle; master is the arbiter, slave is the environment.
interface compound_rr_arbiter_if
    import testbasic13_types::*;
    import compound_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);

    CompoundType          req_in [NUM_REQ];
    logic [NUM_REQ-1:0]   req_in_sync;
    logic [NUM_REQ-1:0]   req_in_notify;
    CompoundType          b_out;
    logic                 b_out_sync;
    logic                 b_out_notify;
    logic [ID_W-1:0]      grant_id;
    logic [CNT_W-1:0]     xfer_count;

    modport master (
        input  req_in,
        input  req_in_sync,
        output req_in_notify,
        output b_out,
        input  b_out_sync,
        output b_out_notify,
        output grant_id,
        output xfer_count
    );

    modport slave (
        output req_in,
        output req_in_sync,
        input  req_in_notify,
        input  b_out,
        output b_out_sync,
        input  b_out_notify,
        input  grant_id,
        input  xfer_count
    );

endinterface

// File: rtl/compound_rr_arbiter_rr_picker.sv
// Round-robin winner selection: first set request scanning upward from last+1, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    int   idx;
    logic found;

    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = ID_W'(idx);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/compound_rr_arbiter.sv
// Shares one CompoundType consumer among NUM_REQ producers with a single output register.
module compound_rr_arbiter
    import testbasic13_types::*;
    import compound_rr_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    compound_rr_arbiter_if.master bus
);

    ArbState_t        state_q, state_d;
    logic [ID_W-1:0]  last_grant_q, last_grant_d;
    CompoundType      b_out_q, b_out_d;
    logic             b_out_notify_q, b_out_notify_d;
    logic [ID_W-1:0]  grant_id_q, grant_id_d;
    logic [CNT_W-1:0] xfer_count_q, xfer_count_d;

    logic             any_req;
    logic [ID_W-1:0]  winner;
    logic [NUM_REQ-1:0] req_notify;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .req    (bus.req_in_sync),
        .last   (last_grant_q),
        .any    (any_req),
        .winner (winner)
    );

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        b_out_d        = b_out_q;
        b_out_notify_d = b_out_notify_q;
        grant_id_d     = grant_id_q;
        xfer_count_d   = xfer_count_q;
        req_notify     = '0;

        case (state_q)
            IDLE: begin
                if (any_req && !rst) begin
                    req_notify     = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    b_out_d        = bus.req_in[winner];
                    grant_id_d     = winner;
                    last_grant_d   = winner;
                    b_out_notify_d = 1'b1;
                    state_d        = SEND;
                end
            end
            SEND: begin
                if (bus.b_out_sync) begin
                    xfer_count_d   = xfer_count_q + 1'b1;
                    b_out_notify_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: begin
                b_out_notify_d = 1'b0;
                state_d        = IDLE;
            end
        endcase
    end

    // Reset drops any held item without counting it and restores index 0 as top priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            last_grant_q   <= ID_W'(NUM_REQ - 1);
            b_out_q        <= '{mode: READ, x: '0, y: '0};
            b_out_notify_q <= 1'b0;
            grant_id_q     <= '0;
            xfer_count_q   <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            b_out_q        <= b_out_d;
            b_out_notify_q <= b_out_notify_d;
            grant_id_q     <= grant_id_d;
            xfer_count_q   <= xfer_count_d;
        end
    end

    assign bus.req_in_notify = req_notify;
    assign bus.b_out         = b_out_q;
    assign bus.b_out_notify  = b_out_notify_q;
    assign bus.grant_id      = grant_id_q;
    assign bus.xfer_count    = xfer_count_q;

endmodule

// File: tb/tb_compound_rr_arbiter.sv
// Self-checking bench for compound_rr_arbiter against a transaction-level reference model.
module tb_compound_rr_arbiter;

    import testbasic13_types::*;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    compound_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    compound_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    bit          chk_en   = 1'b0;

    bit          m_busy;
    int          m_last;
    CompoundType m_hold;
    int          m_gid;
    logic [31:0] m_cnt;
    int          grants[$];
    CompoundType offer[NUM_REQ];

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner is the requester closest after last_grant in circular distance.
    function automatic int pickWinner(input logic [NUM_REQ-1:0] sync, input int last);
        int best = -1;
        int best_d = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sync[i]) begin
                int d = (i - last - 1 + 2 * NUM_REQ) % NUM_REQ;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    task automatic randomizeOffers();
        for (int i = 0; i < NUM_REQ; i++) begin
            offer[i].mode = mode_t'($urandom_range(0, 1));
            offer[i].x    = $urandom;
            offer[i].y    = $urandom;
        end
    endtask

    task automatic applyStimulus(input logic [NUM_REQ-1:0] sync, input logic bsync, input logic r);
        int w;
        logic [NUM_REQ-1:0] exp_notify;
        @(negedge clk);
        rst             = r;
        bus.req_in_sync = sync;
        bus.b_out_sync  = bsync;
        for (int i = 0; i < NUM_REQ; i++) bus.req_in[i] = offer[i];
        #1;
        w          = (!r && !m_busy) ? pickWinner(sync, m_last) : -1;
        exp_notify = (w >= 0) ? NUM_REQ'(1 << w) : '0;
        if (chk_en) begin
            checkOutput("req_in_notify", 128'(bus.req_in_notify), 128'(exp_notify));
            checkOutput("b_out_notify", 128'(bus.b_out_notify), 128'(m_busy));
            checkOutput("b_out", {63'b0, bus.b_out}, {63'b0, m_hold});
            checkOutput("grant_id", 128'(bus.grant_id), 128'(m_gid));
            checkOutput("xfer_count", 128'(bus.xfer_count), 128'(m_cnt));
        end
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0;
            m_last = NUM_REQ - 1;
            m_hold = '{mode: READ, x: 32'd0, y: 32'd0};
            m_gid  = 0;
            m_cnt  = 32'd0;
        end else if (!m_busy) begin
            if (w >= 0) begin
                m_hold = offer[w];
                m_gid  = w;
                m_last = w;
                m_busy = 1'b1;
                grants.push_back(w);
            end
        end else if (bsync) begin
            m_cnt  = m_cnt + 32'd1;
            m_busy = 1'b0;
        end
    endtask

    initial begin
        int base;
        rst             = 1'b1;
        bus.req_in_sync = '0;
        bus.b_out_sync  = 1'b0;
        m_busy = 1'b0; m_last = NUM_REQ - 1; m_gid = 0; m_cnt = 32'd0;
        m_hold = '{mode: READ, x: 32'd0, y: 32'd0};
        randomizeOffers();

        applyStimulus('0, 1'b0, 1'b1);
        chk_en = 1'b1;
        applyStimulus('0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) applyStimulus('0, 1'b0, 1'b0);
        #1;
        checkOutput("idle_b_out", {63'b0, bus.b_out}, {63'b0, READ, 32'd0, 32'd0});

        // Reset while holding an item: nothing counted, index 0 wins afterwards.
        applyStimulus(4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        #1;
        checkOutput("rst_send_notify", 128'(bus.b_out_notify), 128'(0));
        checkOutput("rst_send_count", 128'(bus.xfer_count), 128'(0));
        applyStimulus(4'b1111, 1'b1, 1'b0);
        checkOutput("rst_first_grant", 128'(grants[$]), 128'(0));
        applyStimulus('0, 1'b1, 1'b0);

        offer[2] = '{mode: WRITE, x: 32'd5, y: 32'd1};
        base = int'(m_cnt);
        applyStimulus(4'b0100, 1'b1, 1'b0);
        #1;
        checkOutput("single_b_out", {63'b0, bus.b_out}, {63'b0, WRITE, 32'd5, 32'd1});
        checkOutput("single_grant", 128'(bus.grant_id), 128'(2));
        applyStimulus('0, 1'b1, 1'b0);
        #1;
        checkOutput("single_count", 128'(bus.xfer_count), 128'(base + 1));

        applyStimulus('0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            randomizeOffers();
            applyStimulus(4'b1111, 1'b1, 1'b0);
        end
        #1;
        checkOutput("all4_count", 128'(bus.xfer_count), 128'(5));
        for (int k = 0; k < 5; k++)
            checkOutput("all4_order", 128'(grants[grants.size() - 5 + k]), 128'(k % 4));

        randomizeOffers();
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checkOutput("bp_first_grant", 128'(grants[$]), 128'(1));
        for (int i = 0; i < 6; i++) applyStimulus(4'b1010, 1'b0, 1'b0);
        applyStimulus(4'b1010, 1'b1, 1'b0);
        applyStimulus(4'b1010, 1'b1, 1'b0);
        checkOutput("bp_next_grant", 128'(grants[$]), 128'(3));
        applyStimulus('0, 1'b1, 1'b0);

        for (int i = 0; i < 400; i++) begin
            randomizeOffers();
            applyStimulus(NUM_REQ'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end
        applyStimulus('0, 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);

        // Preload the counter just below wrap, then complete one transfer.
        @(posedge clk);
        #2;
        force dut.xfer_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.xfer_count_q;
        m_cnt = 32'hFFFF_FFFF;
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus('0, 1'b1, 1'b0);
        #1;
        checkOutput("wrap_count", 128'(bus.xfer_count), 128'(0));
        applyStimulus('0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
